// File: rtl/sobel_stream_filter.sv
// Streaming RGB888 pixel processor: passthrough, grayscale, Sobel magnitude
// and binary edge modes. Two line buffers feed a 3x3 window; every valid
// pixel leaves the four-stage pipeline exactly four cycles after it enters.
// The window's bottom-right tap is the current pixel, so filtered output is
// offset by (+1,+1) from the window centre.
module sobel_stream_filter #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  mode,
    input  logic [7:0]  thresh,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    output logic        out_sof,
    output logic [23:0] out_rgb,
    output logic        frame_err
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    // position counters (point at the next expected pixel) and frame mode
    logic [X_W-1:0] cnt_x_q, cnt_x_d, pos_x;
    logic [Y_W-1:0] cnt_y_q, cnt_y_d, pos_y;
    logic           sof_eff, at_origin;
    logic [1:0]     mode_q, mode_d;
    logic           frame_err_q, frame_err_d;
    logic [15:0]    gray_sum;

    // stage 1
    logic           v1_q, v1_d, sof1_q, sof1_d;
    logic [23:0]    rgb1_q, rgb1_d;
    logic [7:0]     gray1_q, gray1_d;
    logic [X_W-1:0] x1_q, x1_d;
    logic [Y_W-1:0] y1_q, y1_d;
    logic [1:0]     mode1_q, mode1_d;

    // line buffers: lb1 holds line y-1, lb2 holds line y-2
    logic [7:0]     lb1_mem [IMG_W];
    logic [7:0]     lb2_mem [IMG_W];
    logic [7:0]     lb1_rd_q, lb2_rd_q;

    // stage 2: window [row][col], row 0 / col 0 are the oldest
    logic [2:0][2:0][7:0] win_q, win_d;
    logic           v2_q, v2_d, sof2_q, sof2_d, border2_q, border2_d;
    logic [23:0]    rgb2_q, rgb2_d;
    logic [7:0]     gray2_q, gray2_d;
    logic [1:0]     mode2_q, mode2_d;

    // stage 3
    logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
    logic           v3_q, v3_d, sof3_q, sof3_d, border3_q, border3_d;
    logic [23:0]    rgb3_q, rgb3_d;
    logic [7:0]     gray3_q, gray3_d;
    logic [1:0]     mode3_q, mode3_d;

    // stage 4
    logic [10:0]    abs_gx, abs_gy;
    logic [11:0]    mag_sum;
    logic [7:0]     mag;
    logic [23:0]    sel_rgb;
    logic           out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic [23:0]    out_rgb_q, out_rgb_d;

    // S1: resolve pixel position, latch mode at (0,0), convert to gray
    always_comb begin
        sof_eff   = in_valid & in_sof;
        pos_x     = sof_eff ? '0 : cnt_x_q;
        pos_y     = sof_eff ? '0 : cnt_y_q;
        at_origin = (pos_x == '0) && (pos_y == '0);
        cnt_x_d   = cnt_x_q;
        cnt_y_d   = cnt_y_q;
        if (in_valid) begin
            if (pos_x == X_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = (pos_y == Y_LAST) ? '0 : pos_y + Y_W'(1);
            end else begin
                cnt_x_d = pos_x + X_W'(1);
                cnt_y_d = pos_y;
            end
        end
        mode_d      = (in_valid && at_origin) ? mode : mode_q;
        frame_err_d = sof_eff && ((cnt_x_q != '0) || (cnt_y_q != '0));
        gray_sum    = 16'd77  * {8'd0, in_rgb[23:16]}
                    + 16'd150 * {8'd0, in_rgb[15:8]}
                    + 16'd29  * {8'd0, in_rgb[7:0]};
        v1_d    = in_valid;
        sof1_d  = sof_eff;
        rgb1_d  = in_rgb;
        gray1_d = 8'(gray_sum >> 8);
        x1_d    = pos_x;
        y1_d    = pos_y;
        mode1_d = at_origin ? mode : mode_q;
    end

    // S2: shift a new column into the window; flag the border region
    always_comb begin
        win_d = win_q;
        if (v1_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_rd_q;
            win_d[1][2] = lb1_rd_q;
            win_d[2][2] = gray1_q;
        end
        v2_d      = v1_q;
        sof2_d    = sof1_q;
        rgb2_d    = rgb1_q;
        gray2_d   = gray1_q;
        mode2_d   = mode1_q;
        border2_d = (x1_q < X_W'(2)) || (y1_q < Y_W'(2));
    end

    // S3: Sobel gradients from the window
    always_comb begin
        gx_pos = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
        gx_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
        gy_pos = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
        gy_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
        gx_d      = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_d      = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
        v3_d      = v2_q;
        sof3_d    = sof2_q;
        rgb3_d    = rgb2_q;
        gray3_d   = gray2_q;
        mode3_d   = mode2_q;
        border3_d = border2_q;
    end

    // S4: saturated magnitude, border mask, threshold and mode mux
    always_comb begin
        abs_gx  = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        abs_gy  = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag_sum = {1'b0, abs_gx} + {1'b0, abs_gy};
        if (border3_q)
            mag = 8'd0;
        else if (mag_sum > 12'd255)
            mag = 8'hFF;
        else
            mag = mag_sum[7:0];
        sel_rgb = rgb3_q;
        case (mode3_q)
            2'd0:    sel_rgb = rgb3_q;
            2'd1:    sel_rgb = {3{gray3_q}};
            2'd2:    sel_rgb = {3{mag}};
            default: sel_rgb = (mag > thresh) ? 24'hFF_FFFF : 24'h00_0000;
        endcase
        out_valid_d = v3_q;
        out_sof_d   = sof3_q;
        out_rgb_d   = v3_q ? sel_rgb : out_rgb_q;
    end

    // pipeline, counter and window registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            mode_q      <= '0;
            frame_err_q <= 1'b0;
            v1_q        <= 1'b0;
            sof1_q      <= 1'b0;
            rgb1_q      <= '0;
            gray1_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            mode1_q     <= '0;
            win_q       <= '0;
            v2_q        <= 1'b0;
            sof2_q      <= 1'b0;
            rgb2_q      <= '0;
            gray2_q     <= '0;
            mode2_q     <= '0;
            border2_q   <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            v3_q        <= 1'b0;
            sof3_q      <= 1'b0;
            rgb3_q      <= '0;
            gray3_q     <= '0;
            mode3_q     <= '0;
            border3_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            cnt_x_q     <= cnt_x_d;
            cnt_y_q     <= cnt_y_d;
            mode_q      <= mode_d;
            frame_err_q <= frame_err_d;
            v1_q        <= v1_d;
            sof1_q      <= sof1_d;
            rgb1_q      <= rgb1_d;
            gray1_q     <= gray1_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            mode1_q     <= mode1_d;
            win_q       <= win_d;
            v2_q        <= v2_d;
            sof2_q      <= sof2_d;
            rgb2_q      <= rgb2_d;
            gray2_q     <= gray2_d;
            mode2_q     <= mode2_d;
            border2_q   <= border2_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            v3_q        <= v3_d;
            sof3_q      <= sof3_d;
            rgb3_q      <= rgb3_d;
            gray3_q     <= gray3_d;
            mode3_q     <= mode3_d;
            border3_q   <= border3_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    // line-buffer RAMs: read for the incoming pixel, write back one stage later
    // (lb1 takes the new gray, lb2 takes what lb1 held at that column)
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_rd_q <= lb1_mem[pos_x];
            lb2_rd_q <= lb2_mem[pos_x];
        end
        if (v1_q) begin
            lb1_mem[x1_q] <= gray1_q;
            lb2_mem[x1_q] <= lb1_rd_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_rgb   = out_rgb_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter on an 8x6 frame. Expected pixels are queued
// when driven and checked, together with latency and out_sof, when they
// emerge; frame_err is checked every cycle.
module tb_sobel_stream_filter;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  thresh = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [23:0] in_rgb = 24'd0;
    logic        out_valid, out_sof, frame_err;
    logic [23:0] out_rgb;

    sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .X_W(3), .Y_W(3)) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .thresh(thresh),
        .in_valid(in_valid), .in_sof(in_sof), .in_rgb(in_rgb),
        .out_valid(out_valid), .out_sof(out_sof), .out_rgb(out_rgb),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] rgb; logic sof; int cyc; } exp_t;
    typedef struct { logic [1:0] mode; logic [23:0] rgb; logic [23:0] exp; } vec_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         err_cyc = -100;
    int         bx = 0;
    int         by = 0;
    logic [1:0] fm = 2'd0;

    always @(posedge clk) cyc++;

    // scoreboard and frame_err checker
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (frame_err !== (cyc == err_cyc)) begin
            bad++;
            $display("FAIL frame_err cyc=%0d got=%b want=%b", cyc, frame_err, (cyc == err_cyc));
        end
        if (out_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out cyc=%0d got=%h want=no output", cyc, out_rgb);
            end else begin
                e = sb.pop_front();
                if (out_rgb !== e.rgb) begin
                    bad++;
                    $display("FAIL out_rgb cyc=%0d got=%h want=%h", cyc, out_rgb, e.rgb);
                end
                total++;
                if (out_sof !== e.sof) begin
                    bad++;
                    $display("FAIL out_sof cyc=%0d got=%b want=%b", cyc, out_sof, e.sof);
                end
                total++;
                if (cyc - e.cyc != 4) begin
                    bad++;
                    $display("FAIL latency cyc=%0d got=%0d want=4", cyc, cyc - e.cyc);
                end
            end
        end
    end

    function automatic logic [7:0] gray_of(input logic [23:0] c);
        logic [31:0] s;
        s = 77 * c[23:16] + 150 * c[15:8] + 29 * c[7:0];
        return s[15:8];
    endfunction

    function automatic logic [7:0] sat4(input logic [7:0] g);
        int v;
        v = 4 * g;
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] rgb, input logic sof, input logic [23:0] ex);
        exp_t e;
        if (sof) begin
            if (bx != 0 || by != 0) err_cyc = cyc + 1;
            bx = 0;
            by = 0;
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_rgb   = rgb;
        e.rgb = ex;
        e.sof = sof;
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_rgb   = 24'($urandom);
        bx++;
        if (bx == W) begin
            bx = 0;
            by++;
            if (by == H) by = 0;
        end
    endtask

    // column pattern: x<4 black, x>=4 'hi'; only x=4,5 on rows>=2 see an edge
    task automatic pat_px(input logic sof, input logic [23:0] hi);
        int px, py;
        logic [23:0] rgb, ex;
        logic [7:0] m;
        px = sof ? 0 : bx;
        py = sof ? 0 : by;
        if (px == 0 && py == 0) fm = mode;
        rgb = (px >= 4) ? hi : 24'h0;
        m = (py >= 2 && (px == 4 || px == 5)) ? sat4(gray_of(hi)) : 8'h0;
        case (fm)
            2'd0:    ex = rgb;
            2'd1:    ex = {3{gray_of(rgb)}};
            2'd2:    ex = {3{m}};
            default: ex = (m > thresh) ? 24'hFFFFFF : 24'h0;
        endcase
        send(rgb, sof, ex);
    endtask

    task automatic frame_pat(input logic sof_first, input logic [23:0] hi, input bit gaps, input int sw);
        for (int i = 0; i < W * H; i++) begin
            if (i == sw) mode = 2'd0;
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            pat_px(sof_first && (i == 0), hi);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({out_valid, out_sof, out_rgb, frame_err} !== 27'd0) begin
            bad++;
            $display("FAIL %s got v=%b s=%b rgb=%h err=%b want all 0", name, out_valid, out_sof, out_rgb, frame_err);
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 24'h123456, 24'h123456};
        vecs[1] = '{2'd1, 24'hFF0000, 24'h4C4C4C};
        vecs[2] = '{2'd1, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{2'd1, 24'h101010, 24'h101010};
        vecs[4] = '{2'd1, 24'h00FF00, 24'h959595};
        vecs[5] = '{2'd1, 24'h0000FF, 24'h1C1C1C};
        vecs[6] = '{2'd0, 24'hABCDEF, 24'hABCDEF};
        vecs[7] = '{2'd1, 24'h000000, 24'h000000};

        // reset with random inputs
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            in_sof   = 1'($urandom);
            in_rgb   = 24'($urandom);
            mode     = 2'($urandom);
            thresh   = 8'($urandom);
            @(negedge clk);
            check_zero("reset_outputs");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        mode     = 2'd0;
        thresh   = 8'd0;
        rstn     = 1'b1;
        idle(2);

        // uniform frames, passthrough and grayscale
        for (int v = 0; v < 8; v++) begin
            mode = vecs[v].mode;
            for (int i = 0; i < W * H; i++) begin
                if ($urandom_range(0, 4) == 0) idle(1);
                send(vecs[v].rgb, i == 0, vecs[v].exp);
            end
        end

        // Sobel magnitude; second frame has no in_sof and relies on wrap
        mode = 2'd2;
        frame_pat(1'b1, 24'hFFFFFF, 1'b1, -1);
        frame_pat(1'b0, 24'hFFFFFF, 1'b0, -1);

        // binary edge at both sides of the threshold, then a mid-frame mode change
        idle(6);
        thresh = 8'd63;
        mode = 2'd3;
        frame_pat(1'b1, 24'h101010, 1'b0, -1);
        idle(6);
        thresh = 8'd64;
        frame_pat(1'b1, 24'h101010, 1'b1, -1);
        idle(6);
        thresh = 8'd63;
        frame_pat(1'b1, 24'h101010, 1'b0, 20);
        frame_pat(1'b1, 24'h101010, 1'b0, -1);

        // misplaced in_sof at pixel index 10, then a clean frame
        idle(6);
        mode = 2'd2;
        for (int i = 0; i < 10; i++) pat_px(1'b0, 24'hFFFFFF);
        frame_pat(1'b1, 24'hFFFFFF, 1'b0, -1);
        frame_pat(1'b1, 24'hFFFFFF, 1'b0, -1);

        // reset mid-frame: pipeline flushes, next pixel is (0,0) without in_sof
        mode = 2'd1;
        for (int i = 0; i < 5; i++) send(24'h808080, 1'b0, 24'h808080);
        rstn = 1'b0;
        sb.delete();
        bx = 0;
        by = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("midframe_reset");
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mode = 2'd2;
        frame_pat(1'b0, 24'hFFFFFF, 1'b0, -1);

        // drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_stream_filter.md
# sobel_stream_filter

Parametrised streaming pixel processor that sits between the VGA pixel-coordinate generator and the colour output path. It replaces the fixed single-mode Sobel/picture path with a frame-size-generic engine: RGB888 in, RGB888 out, four runtime modes (passthrough, grayscale, Sobel magnitude, binary edge). It uses two on-chip line buffers and has a fixed pipeline latency of 4 cycles per valid pixel.

## Interface
- IMG_W, 800, active pixels per line.
- IMG_H, 480, active lines per frame.
- X_W, 10, x counter width; must satisfy 2^X_W >= IMG_W.
- Y_W, 10, y counter width; must satisfy 2^Y_W >= IMG_H.
- clk  in  1  pixel clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- mode  in  2  0 passthrough, 1 grayscale, 2 Sobel magnitude, 3 binary edge.
- thresh  in  8  edge threshold for mode 3.
- in_valid  in  1  in_rgb carries a pixel this cycle.
- in_sof  in  1  start of frame; meaningful only with in_valid.
- in_rgb  in  24  {R[23:16], G[15:8], B[7:0]}.
- out_valid  out  1  out_rgb valid.
- out_sof  out  1  delayed in_sof.
- out_rgb  out  24  processed pixel.
- frame_err  out  1  one-cycle pulse on a misplaced in_sof.

## Operation
- Position counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on in_valid.
  - x wraps to 0 and y increments after IMG_W-1.
  - After (IMG_W-1, IMG_H-1), both counters wrap to (0,0).
- in_valid & in_sof marks the pixel as (0,0).
  - If the counters were not already at (0,0), frame_err pulses and the counters restart at (0,0) for that pixel.
- Mode latch:
  - mode_q captures mode on every valid pixel at position (0,0) and applies from that pixel onward.
  - mode changes mid-frame are ignored until the next frame.
  - thresh is sampled live.
- Grayscale: gray = (77R + 150G + 29B)[15:8]. The 16-bit sum cannot overflow.
- Line buffers:
  - Two IMG_W x 8 synchronous-read RAMs hold gray for lines y-1 and y-2, addressed by x, written on in_valid.
  - A 3x3 window shift register takes one column per valid pixel.
- Window alignment: the window's bottom-right element is the current pixel (x,y). The output is therefore spatially shifted by (+1,+1) from the centre.
- Sobel:
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20), where pRC is row R (0 = oldest) and column C (0 = oldest). Signed 11 bits.
  - Gy is the transposed form, also signed 11 bits.
  - mag = |Gx| + |Gy| (12 bits), saturated to 255.
- Border: if x < 2 or y < 2, mag is forced to 0. This masks stale line-buffer data.
- Output mux per mode_q:
  - 0: in_rgb delayed.
  - 1: {gray, gray, gray}.
  - 2: {mag, mag, mag}.
  - 3: 24'hFFFFFF if mag > thresh (strictly greater), else 0.
- Pipeline stalls: none. Invalid cycles leave the window, counters and line buffers unchanged; bubbles propagate as out_valid = 0.

## Timing
- Reset values: out_valid = 0, out_sof = 0, out_rgb = 0, frame_err = 0; counters (0,0); mode_q = 0; window registers 0. Line-buffer RAM contents are not reset.
- Latency: in_valid at edge t produces out_valid, out_sof and out_rgb at edge t+4, regardless of mode. Stages:
  - S1: gray, position and mode capture.
  - S2: line-buffer read and window shift.
  - S3: Gx/Gy.
  - S4: magnitude, threshold, mux.
- Throughput: one pixel per clock with back-to-back in_valid.
- frame_err is asserted at edge t+1 after the offending in_sof.
- Reset mid-frame: the pipeline flushes (no out_valid for 4 cycles after release). The first valid pixel after release is (0,0), with or without in_sof.
- Simultaneous end of frame and in_sof: in_sof on the pixel immediately following (IMG_W-1, IMG_H-1) is legal and raises no frame_err.

## Test plan
Bench uses IMG_W=8, IMG_H=6.
1. Reset held 5 cycles with random inputs -> all outputs 0; release, first out_valid exactly 4 cycles after first in_valid.
2. Mode 0, stream in_rgb = 0x123456 -> out_rgb = 0x123456 at t+4, out_sof aligned to input in_sof.
3. Mode 1: in 0xFF0000 -> 0x4C4C4C; in 0xFFFFFF -> 0xFFFFFF; in 0x101010 -> 0x101010.
4. Mode 2, columns 0-3 = 0x000000 and 4-7 = 0xFFFFFF every row:
   - rows y >= 2: x = 4,5 -> 0xFFFFFF; x = 0-3, 6, 7 -> 0.
   - rows 0-1: all 0.
5. Mode 3, columns 0-3 = 0, 4-7 = 0x101010 (|Gx| = 64, |Gy| = 0):
   - thresh = 63 -> 0xFFFFFF at x = 4,5 (y >= 2).
   - thresh = 64 -> all 0.
   - Switching mode to 0 mid-frame takes effect only at the next (0,0).
6. in_sof asserted at pixel index 10 -> frame_err high for one cycle at t+1; that pixel treated as (0,0); next full frame produces no frame_err.
